// File: rtl/obi_mem_slave.sv
// Memory-backed OBI responder: byte-enabled word array with in-order, fixed-latency responses.
// Latency: RSP_LATENCY cycles from grant to rvalid_o; misaligned/out-of-range accesses return err_o.
// Backpressure: gnt_o drops while MAX_OUTSTANDING responses are pending, unless one retires this cycle.
module obi_mem_slave #(
    parameter int          MEM_DEPTH       = 4096,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          RSP_LATENCY     = 1,
    parameter int          MAX_OUTSTANDING = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int              AW      = $clog2(MEM_DEPTH);
    localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0]     SPAN    = 32'(4 * MEM_DEPTH);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);

    typedef struct packed {
        logic        vld;
        logic        err;
        logic [31:0] rdata;
    } rsp_t;

    logic [31:0]   mem_q [MEM_DEPTH];
    rsp_t          rsp_q [RSP_LATENCY];
    rsp_t          rsp_d [RSP_LATENCY];
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0]   off;
    logic [AW-1:0] idx;
    logic          in_range, aligned, good, accept, retire;

    // The subtraction wraps for addresses below BASE_ADDR, which then fail the range test.
    assign off      = addr_i - BASE_ADDR;
    assign in_range = off < SPAN;
    assign aligned  = (addr_i[1:0] == 2'b00);
    assign good     = in_range && aligned;
    assign idx      = off[AW+1:2];

    assign retire = rsp_q[RSP_LATENCY-1].vld;
    assign gnt_o  = !rst && ((cnt_q < MAX_CNT) || retire);
    assign accept = req_i && gnt_o;

    always_comb begin
        rsp_d[0] = '0;
        if (accept) begin
            rsp_d[0].vld   = 1'b1;
            rsp_d[0].err   = !good;
            rsp_d[0].rdata = (good && !we_i) ? mem_q[idx] : 32'h0;
        end
        for (int i = 1; i < RSP_LATENCY; i++) begin
            rsp_d[i] = rsp_q[i-1];
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({accept, retire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < RSP_LATENCY; i++) begin
                rsp_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < RSP_LATENCY; i++) begin
                rsp_q[i] <= rsp_d[i];
            end
        end
    end

    // Contents survive reset; accept is already blocked while rst is high.
    always_ff @(posedge clk) begin
        if (accept && good && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Invalid stages carry zero data, so only reset needs masking here.
    assign rvalid_o = retire && !rst;
    assign err_o    = rsp_q[RSP_LATENCY-1].err && !rst;
    assign rdata_o  = rst ? 32'h0 : rsp_q[RSP_LATENCY-1].rdata;

endmodule

// File: tb/tb_obi_mem_slave.sv
// Bench for obi_mem_slave: two instances (latency 1/1 at base 0, latency 3/2 at a non-zero base),
// a queue-based scoreboard fed by the driver and drained by a negedge monitor.
module tb_obi_mem_slave;

    localparam int          DEPTH = 64;
    localparam int          LAT0  = 1;
    localparam int          MO0   = 1;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam int          LAT1  = 3;
    localparam int          MO1   = 2;
    localparam logic [31:0] BASE1 = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst    [2];
    logic        req    [2];
    logic        gnt    [2];
    logic [31:0] addr   [2];
    logic        we     [2];
    logic [3:0]  be     [2];
    logic [31:0] wdata  [2];
    logic        rvalid [2];
    logic [31:0] rdata  [2];
    logic        err    [2];

    always #5 clk = ~clk;

    obi_mem_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE0), .RSP_LATENCY(LAT0), .MAX_OUTSTANDING(MO0)) u_dut0 (
        .clk(clk), .rst(rst[0]), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]), .we_i(we[0]),
        .be_i(be[0]), .wdata_i(wdata[0]), .rvalid_o(rvalid[0]), .rdata_o(rdata[0]), .err_o(err[0])
    );

    obi_mem_slave #(.MEM_DEPTH(DEPTH), .BASE_ADDR(BASE1), .RSP_LATENCY(LAT1), .MAX_OUTSTANDING(MO1)) u_dut1 (
        .clk(clk), .rst(rst[1]), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]), .we_i(we[1]),
        .be_i(be[1]), .wdata_i(wdata[1]), .rvalid_o(rvalid[1]), .rdata_o(rdata[1]), .err_o(err[1])
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          due;
    } exp_t;

    exp_t        fifo [2][16];
    int          wp   [2];
    int          rp   [2];
    logic [31:0] mdl  [2][DEPTH];
    logic [31:0] last_rdata [2];
    logic        last_err   [2];
    bit          gnt_log [$];
    int          tests = 0;
    int          fails = 0;
    int          cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic int mo(input int k);
        return (k == 0) ? MO0 : MO1;
    endfunction

    function automatic logic [31:0] base(input int k);
        return (k == 0) ? BASE0 : BASE1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Reference memory: byte address -> word, errors for anything outside the window or misaligned.
    function automatic void model(input int k, input logic [31:0] a, input logic w, input logic [3:0] b,
                                  input logic [31:0] d, output logic e_err, output logic [31:0] e_rd);
        logic [31:0] off;
        int          widx;
        off   = a - base(k);
        e_rd  = 32'h0;
        e_err = 1'b0;
        if (off >= 32'(4 * DEPTH) || (a % 4) != 0) begin
            e_err = 1'b1;
        end else begin
            widx = int'(off / 4);
            if (w) begin
                for (int i = 0; i < 4; i++) begin
                    if (b[i]) mdl[k][widx][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                e_rd = mdl[k][widx];
            end
        end
    endfunction

    task automatic mon(input int k);
        int   n;
        logic eg;
        exp_t e;
        n = wp[k] - rp[k];
        if (rst[k]) begin
            chk($sformatf("u%0d gnt in reset", k), 32'(gnt[k]), 32'h0);
            chk($sformatf("u%0d rvalid in reset", k), 32'(rvalid[k]), 32'h0);
            rp[k] = wp[k];
            return;
        end
        eg = (n < mo(k)) || (n > 0 && fifo[k][rp[k] % 16].due == cyc);
        chk($sformatf("u%0d gnt", k), 32'(gnt[k]), 32'(eg));
        if (rvalid[k]) begin
            last_rdata[k] = rdata[k];
            last_err[k]   = err[k];
            if (n == 0) begin
                tests++;
                fails++;
                $display("FAIL u%0d unexpected rvalid: got 1 expected 0 (cycle %0d)", k, cyc);
            end else begin
                e = fifo[k][rp[k] % 16];
                rp[k]++;
                chk($sformatf("u%0d rsp err", k), 32'(err[k]), 32'(e.err));
                chk($sformatf("u%0d rsp rdata", k), rdata[k], e.rdata);
                chk($sformatf("u%0d rsp cycle", k), 32'(cyc), 32'(e.due));
            end
        end else begin
            chk($sformatf("u%0d idle rdata", k), rdata[k], 32'h0);
            chk($sformatf("u%0d idle err", k), 32'(err[k]), 32'h0);
            if (n > 0 && fifo[k][rp[k] % 16].due <= cyc) begin
                tests++;
                fails++;
                $display("FAIL u%0d missing rvalid: got 0 expected 1 (cycle %0d)", k, cyc);
                rp[k]++;
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) mon(k);
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the grant.
    task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [3:0] b,
                        input logic [31:0] d);
        int          n;
        bit          done;
        logic        e_err;
        logic [31:0] e_rd;
        n    = 0;
        done = 0;
        req[k] = 1'b1; addr[k] = a; we[k] = w; be[k] = b; wdata[k] = d;
        while (!done) begin
            @(negedge clk);
            #1;
            gnt_log.push_back(gnt[k]);
            if (gnt[k]) begin
                model(k, a, w, b, d, e_err, e_rd);
                fifo[k][wp[k] % 16] = '{e_err, e_rd, cyc + lat(k)};
                wp[k]++;
                done = 1;
            end else if (++n > 20) begin
                tests++;
                fails++;
                $display("FAIL u%0d grant timeout: got 0 expected 1 (cycle %0d)", k, cyc);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        req[k] = 1'b0;
    endtask

    task automatic idle(input int k, input int n);
        req[k] = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [31:0] raddr(input int k);
        int          r;
        logic [31:0] a;
        r = int'($urandom_range(0, 9));
        a = base(k) + 32'(4 * $urandom_range(0, DEPTH - 1));
        if (r == 7)      a = a | 32'($urandom_range(1, 3));
        else if (r == 8) a = base(k) + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
        else if (r == 9) a = base(k) - 32'(4 * $urandom_range(1, 16));
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0;
        int          ones;
        logic [5:0]  pat;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; addr[k] = '0; we[k] = 1'b0; be[k] = '0; wdata[k] = '0;
            wp[k] = 0; rp[k] = 0; last_rdata[k] = '0; last_err[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        idle(0, 3);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) xfer(k, base(k) + 32'(4 * i), 1'b1, 4'hF, $urandom);
        end

        // Byte-enable merge, misaligned read, out-of-range write.
        xfer(0, 32'h10, 1'b1, 4'hF, 32'h1122_3344);
        xfer(0, 32'h10, 1'b1, 4'b0101, 32'hAABB_CCDD);
        xfer(0, 32'h10, 1'b0, 4'h0, 32'h0);
        idle(0, 2);
        chk("be merge rdata", last_rdata[0], 32'h11BB_33DD);
        chk("be merge err", 32'(last_err[0]), 32'h0);
        xfer(0, 32'h2, 1'b0, 4'hF, 32'h0);
        idle(0, 2);
        chk("misaligned err", 32'(last_err[0]), 32'h1);
        chk("misaligned rdata", last_rdata[0], 32'h0);
        xfer(0, 32'(4 * DEPTH), 1'b1, 4'hF, 32'hDEAD_BEEF);
        idle(0, 2);
        chk("out of range err", 32'(last_err[0]), 32'h1);
        xfer(0, 32'h0, 1'b0, 4'h0, 32'h0);
        idle(0, 2);

        // Streaming write/read pairs to one word.
        gnt_log.delete();
        c0 = cyc;
        for (int i = 0; i < 20; i++) begin
            xfer(0, 32'h20, 1'b1, 4'hF, 32'h100 + 32'(i));
            xfer(0, 32'h20, 1'b0, 4'h0, 32'h0);
        end
        chk("stream cycles", 32'(cyc - c0), 32'd40);
        ones = 0;
        foreach (gnt_log[i]) ones += int'(gnt_log[i]);
        chk("stream grants", 32'(ones), 32'd40);
        idle(0, 2);

        // Throttling with req held high for six reads.
        gnt_log.delete();
        for (int i = 0; i < 6; i++) xfer(1, BASE1 + 32'(4 * i), 1'b0, 4'h0, 32'h0);
        pat = 6'b110110;
        chk("throttle cycles", 32'(gnt_log.size()), 32'd8);
        for (int i = 0; i < 6; i++) chk($sformatf("throttle gnt[%0d]", i), 32'(gnt_log[i]), 32'(pat[5 - i]));
        idle(1, 5);

        xfer(1, BASE1 - 32'h4, 1'b0, 4'h0, 32'h0);
        idle(1, 4);
        chk("underflow err", 32'(last_err[1]), 32'h1);

        // Reset with two reads in flight; the monitor flags any stray rvalid.
        xfer(1, BASE1 + 32'h8, 1'b0, 4'h0, 32'h0);
        xfer(1, BASE1 + 32'hC, 1'b0, 4'h0, 32'h0);
        rst[1] = 1'b1;
        idle(1, 1);
        rst[1] = 1'b0;
        idle(1, 6);
        xfer(1, BASE1 + 32'h8, 1'b0, 4'h0, 32'h0);
        idle(1, 5);

        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 3) == 0) idle(k, int'($urandom_range(1, 3)));
                xfer(k, raddr(k), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
            end
        end
        idle(1, 6);
        chk("drain u0", 32'(wp[0] - rp[0]), 32'h0);
        chk("drain u1", 32'(wp[1] - rp[1]), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/obi_mem_slave.md
# obi_mem_slave

Memory-backed OBI responder. It is the target end of the core's `instr_*`/`data_*` request/grant/rvalid bus. It accepts address-phase requests, applies byte-enabled writes to an internal word array, and returns in-order responses after a fixed latency. It flags misaligned and out-of-range accesses. It sits in the SoC/testbench fabric behind the core's instruction or data port.

## Interface
Parameters:
- `MEM_DEPTH` — default 4096 — number of 32-bit words; power of two.
- `BASE_ADDR` — default 32'h0000_0000 — byte address of word 0; aligned to `4*MEM_DEPTH`.
- `RSP_LATENCY` — default 1 — cycles from grant to `rvalid_o`; legal range 1..4.
- `MAX_OUTSTANDING` — default 1 — maximum accepted-but-unanswered transactions; legal range 1..`RSP_LATENCY`.

Ports:
- `clk` — in — 1 — single clock; all logic on the rising edge.
- `rst` — in — 1 — reset, synchronous, active-high.
- `req_i` — in — 1 — address-phase request.
- `gnt_o` — out — 1 — grant. A transfer is accepted on a cycle where `req_i && gnt_o`.
- `addr_i` — in — 32 — byte address.
- `we_i` — in — 1 — 1 = write, 0 = read.
- `be_i` — in — 4 — byte enables; bit n selects `wdata_i[8n+7:8n]`.
- `wdata_i` — in — 32 — write data.
- `rvalid_o` — out — 1 — response valid, one cycle per accepted transfer.
- `rdata_o` — out — 32 — read data. It is 0 for writes and errors.
- `err_o` — out — 1 — error response; qualified by `rvalid_o`.

## Operation
- Address decode:
  - `in_range` = (`addr_i` - `BASE_ADDR`) < 4*`MEM_DEPTH`, compared unsigned over 32 bits.
  - `aligned` = (`addr_i[1:0]` == 0).
  - Word index = (`addr_i` - `BASE_ADDR`)[log2(MEM_DEPTH)+1:2].
- On acceptance, a good access (`in_range && aligned`) behaves as follows:
  - Write: each byte with `be_i[n]`=1 is written at the accepting edge. `be_i`=0 is a legal no-op write with a normal response.
  - Read: the word is sampled at the accepting edge. It reflects every write accepted in earlier cycles.
- A bad access (not in range or not aligned) leaves memory unmodified. Its response is `err_o`=1, `rdata_o`=0.
- Response pipeline: a shift register of `RSP_LATENCY` stages. Each stage holds {valid, err, rdata}.
  - An accepted transfer enters stage 0.
  - Stage `RSP_LATENCY-1` drives `rvalid_o`/`err_o`/`rdata_o`.
  - Responses are strictly in acceptance order. There is no back-pressure, because the requester always accepts `rvalid_o`.
- Outstanding counter `cnt` (width clog2(`MAX_OUTSTANDING`+1)):
  - +1 on accept, -1 on `rvalid_o`.
  - Unchanged when both happen in the same cycle.
- `gnt_o` = !`rst` && (`cnt` < `MAX_OUTSTANDING` || `retire`), where `retire` = last stage valid.
  - `gnt_o` is combinational from registered state only; it never depends on `req_i`.
- Request signals may change freely while `gnt_o`=0. Nothing is sampled unless `req_i && gnt_o`.
- Memory contents are not reset.

## Timing
- Reset values while `rst`=1 and on the first cycle after deassertion:
  - `rvalid_o`=0, `rdata_o`=0, `err_o`=0.
  - `gnt_o` is 0 during `rst` and 1 on the first cycle after deassertion.
  - `cnt`=0; all pipeline stages are invalid.
- Latency: a transfer accepted at edge T produces `rvalid_o`=1 during cycle T+`RSP_LATENCY`. `rdata_o`/`err_o` are valid only in that cycle; otherwise they are driven 0.
- Throughput:
  - With `MAX_OUTSTANDING`=`RSP_LATENCY`: one transfer per cycle.
  - With `MAX_OUTSTANDING`=1, `RSP_LATENCY`=1: one transfer per cycle, using grant-on-retire.
  - With `MAX_OUTSTANDING`=1, `RSP_LATENCY`=2: one transfer every 2 cycles.
- Back-to-back write then read to the same word at T, T+1: the read returns the written data.
- A read and a write cannot target the same word in the same cycle, since there is one port.
- Reset mid-operation: pending responses are dropped with no `rvalid_o`, `cnt` returns to 0, and memory writes already performed are kept.
- Address wrap: with `BASE_ADDR`≠0, addresses below `BASE_ADDR` underflow in the subtraction. They are therefore out of range and produce an error.

## Test plan
- Reset then idle: `rst` high 3 cycles → `gnt_o`=0, `rvalid_o`=0. After release `gnt_o`=1 and `rvalid_o` stays 0 with `req_i`=0.
- Byte-enable write/read (`RSP_LATENCY`=1):
  - Write 0x11223344, `be`=4'hF to 0x10.
  - Write 0xAABBCCDD, `be`=4'b0101 to 0x10.
  - Read 0x10 → rdata 0x11BB33DD with `err_o`=0. Each response comes exactly 1 cycle after its grant.
- Errors:
  - Read at 0x02 (misaligned) → `err_o`=1, rdata 0.
  - Write to `BASE_ADDR`+4*`MEM_DEPTH` → `err_o`=1, and a later read of word 0 is unchanged.
- Throttling (`RSP_LATENCY`=3, `MAX_OUTSTANDING`=2), `req_i` held high for 6 reads of 0x0, 0x4, …:
  - `gnt_o` pattern 1,1,0,1,1,0.
  - 6 in-order `rvalid_o` pulses, each 3 cycles after its grant.
  - `cnt` never exceeds 2.
- Reset mid-flight: accept 2 reads with `RSP_LATENCY`=3, assert `rst` one cycle later → no `rvalid_o` ever appears for them. A post-reset read returns correct data.
- Streaming (`RSP_LATENCY`=1, `MAX_OUTSTANDING`=1): write-then-read every cycle to the same address with incrementing data → `gnt_o` held 1 and every read returns the preceding write's data.
